// File: rtl/spacing_fn_pwl.sv
// spacing_fn_pwl: programmable piecewise-linear odd-symmetric mapper from sign-magnitude
// fixed point to fp32, 3-stage pipeline with valid/ready and a runtime-writable breakpoint table.
module spacing_fn_pwl #(
  parameter int IN_W     = 8,
  parameter int FRAC_W   = 5,
  parameter int SEG_BITS = 4,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [IN_W-1:0]     i_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [31:0]         o_data,
  input  logic                cfg_we,
  input  logic [SEG_BITS:0]   cfg_addr,
  input  logic [OUT_W-1:0]    cfg_wdata
);
  localparam int IB   = IN_W - 1 - SEG_BITS;
  localparam int NSEG = 1 << SEG_BITS;
  localparam int SH   = IB + OUT_FRAC - FRAC_W;
  localparam int MW   = OUT_W + IB + 2;
  localparam int YMAX = (1 << OUT_W) - 1;

  logic [OUT_W-1:0]     tbl [NSEG+1];
  logic                 en, v1, v2, sg1, sg2, z1, z2;
  logic [IB-1:0]        f1;
  logic [OUT_W-1:0]     a1, b1, y2, y_n;
  logic [SEG_BITS:0]    k0, k1;
  logic signed [MW-1:0] lo, hi, fs, ys;
  logic [4:0]           msb;
  logic [7:0]           ex;
  logic [22:0]          man;

  assign en      = !o_valid || o_ready;
  assign i_ready = en;
  assign k0      = {1'b0, i_data[IN_W-2 -: SEG_BITS]};
  assign k1      = k0 + (SEG_BITS+1)'(1);

  // reset loads the identity mapping f(x) = x
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i <= NSEG; i++)
        tbl[i] <= (i << SH) > YMAX ? OUT_W'(YMAX) : OUT_W'(i << SH);
    else if (cfg_we && cfg_addr <= (SEG_BITS+1)'(NSEG))
      tbl[cfg_addr] <= cfg_wdata;

  always_ff @(posedge clk)
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (en) begin
      v1      <= i_valid;
      sg1     <= i_data[IN_W-1];
      z1      <= i_data[IN_W-2:0] == '0;
      f1      <= i_data[IB-1:0];
      a1      <= tbl[k0];
      b1      <= tbl[k1];
      v2      <= v1;
      sg2     <= sg1;
      z2      <= z1;
      y2      <= y_n;
      o_valid <= v2;
      o_data  <= (z2 || y2 == '0) ? '0 : {sg2, ex, man};
    end

  // floor shift keeps decreasing segments monotone; clamp guards the output range
  always_comb begin
    lo  = MW'(a1);
    hi  = MW'(b1);
    fs  = MW'(f1);
    ys  = lo + (((hi - lo) * fs) >>> IB);
    y_n = ys < 0 ? '0 : ys > MW'(YMAX) ? OUT_W'(YMAX) : ys[OUT_W-1:0];
  end

  always_comb begin
    msb = '0;
    for (int i = 0; i < OUT_W; i++)
      if (y2[i]) msb = 5'(i);
    ex  = 8'(127 + int'(msb) - OUT_FRAC);
    man = 23'(24'(y2) << (5'd23 - msb));
  end
endmodule
